// File: rtl/csa_seq_sub.sv
// Multi-cycle WIDTH-bit subtractor (diff = x - y - bin) resolving one
// SLICE-bit carry-select slice per clock, with start/busy/done handshake.
module csa_seq_sub #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned SLICE = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  localparam int unsigned NSLICE = WIDTH / SLICE;
  localparam int unsigned IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] x_q, yn_q, acc_q, diff_q;
  logic [IDXW-1:0]  idx_q;
  logic             carry_q, busy_q, done_q, bout_q;

  logic [SLICE-1:0] xs, ysn;
  logic [SLICE:0]   s0, s1, sel;
  logic [WIDTH-1:0] acc_d;
  logic             last;

  // Borrow chain runs as an inverted carry: x + ~y + ~bin.
  always_comb begin
    xs  = '0;
    ysn = '0;
    for (int unsigned i = 0; i < NSLICE; i++) begin
      if (idx_q == IDXW'(i)) begin
        xs  = x_q[i*SLICE +: SLICE];
        ysn = yn_q[i*SLICE +: SLICE];
      end
    end
    s0  = {1'b0, xs} + {1'b0, ysn};
    s1  = {1'b0, xs} + {1'b0, ysn} + {{SLICE{1'b0}}, 1'b1};
    sel = carry_q ? s1 : s0;
    acc_d = acc_q;
    for (int unsigned i = 0; i < NSLICE; i++) begin
      if (idx_q == IDXW'(i)) acc_d[i*SLICE +: SLICE] = sel[SLICE-1:0];
    end
    last = (idx_q == IDXW'(NSLICE - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      x_q     <= '0;
      yn_q    <= '0;
      acc_q   <= '0;
      diff_q  <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      bout_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          done_q <= 1'b0;
          if (start) begin
            x_q     <= x;
            yn_q    <= ~y;
            carry_q <= ~bin;
            idx_q   <= '0;
            state_q <= RUN;
            busy_q  <= 1'b1;
          end else begin
            state_q <= IDLE;
          end
        end
        RUN: begin
          acc_q   <= acc_d;
          carry_q <= sel[SLICE];
          idx_q   <= idx_q + 1'b1;
          if (last) begin
            diff_q  <= acc_d;
            bout_q  <= ~sel[SLICE];
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= DONE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign diff = diff_q;
  assign bout = bout_q;

endmodule

// File: doc/csa_seq_sub.md
Name: csa_seq_sub

Overview:
- Multi-cycle WIDTH-bit subtractor: diff = x - y - bin, with borrow-out.
- Uses one carry-select slice of SLICE bits per clock; this is the subtract-side counterpart of the team's 64-bit carry-select adder.
- Trades latency for area in datapaths that need a wide difference and a borrow, for example compare/decrement paths feeding the adder.
- Start/busy/done handshake; result is held stable until the next accepted start.

Parameters:
WIDTH, 64, operand and result width; must be a multiple of SLICE
SLICE, 16, bits resolved per cycle by the carry-select slice; NSLICE = WIDTH/SLICE (4 by default)

Ports:
clk     input   1      rising-edge clock
rst_n   input   1      asynchronous active-low reset
start   input   1      request; sampled on a rising edge while busy==0
x       input   WIDTH  minuend; sampled with an accepted start
y       input   WIDTH  subtrahend; sampled with an accepted start
bin     input   1      borrow-in; sampled with an accepted start
busy    output  1      high while a subtraction is in progress
done    output  1      one-cycle pulse when diff/bout are updated
diff    output  WIDTH  result x - y - bin (mod 2^WIDTH); registered
bout    output  1      borrow-out; 1 iff x < y + bin (unsigned)

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE; busy=0, done=0, diff=0, bout=0; internal operands, accumulator, slice index and carry cleared. Outputs stay at these values until the first completed operation.
- States: IDLE, RUN, DONE.
- IDLE or DONE with start=1 at edge k:
  - latch x, y and ~y into operand registers;
  - carry <= ~bin, idx <= 0;
  - state <= RUN, busy <= 1, done <= 0.
- IDLE or DONE with start=0: state <= IDLE, done <= 0.
- RUN, each edge processes slice idx, bits [idx*SLICE +: SLICE]:
  - s0 = xs + ~ys + 0 and s1 = xs + ~ys + 1 are computed in parallel (SLICE+1 bits each);
  - select s1 if carry==1, else s0;
  - the selected low SLICE bits go into the accumulator slice; the selected MSB becomes the new carry;
  - idx <= idx + 1.
- Last slice (idx == NSLICE-1) at edge k+NSLICE:
  - diff <= full accumulator, including the final slice;
  - bout <= ~final carry;
  - done <= 1, busy <= 0, state <= DONE.
- DONE lasts exactly one cycle. The next edge clears done and goes to IDLE, unless start=1, which begins a new operation (back-to-back).
- Latency: done is asserted NSLICE edges after the start-sampling edge. Back-to-back throughput is one result per NSLICE+1 cycles.
- start while busy==1 is ignored: operands are not re-sampled and the timing is unaffected.
- Changes on x, y or bin after acceptance have no effect on the result.
- diff and bout change only on the done edge. They never show partial results and hold their value through IDLE.
- Arithmetic is unsigned modulo 2^WIDTH. The borrow chain is carried as an inverted carry: carry-in = ~bin, bout = ~carry-out.
- Reset asserted mid-RUN aborts immediately: no done pulse; all outputs return to reset values.
- The idx counter is sized as clog2(NSLICE), minimum 1 bit. It is never compared beyond NSLICE-1, and wrap is unreachable.

Test Plan:
1. Equal operands: x=y=64'hAAAA_AAAA_AAAA_AAAA, bin=0, start pulse → busy high for 4 cycles; done pulse 4 edges after start; diff=0, bout=0.
2. Borrow through all slices: x=0, y=1, bin=0 → diff=64'hFFFF_FFFF_FFFF_FFFF, bout=1.
3. Borrow-in plus slice-boundary carry: x=64'h0000_0000_0001_0000, y=0, bin=1 → diff=64'h0000_0000_0000_FFFF, bout=0. Then x=5, y=3, bin=1 → diff=1, bout=0.
4. Ignored start: during the busy window of test 1, pulse start with x=7, y=2 → result unchanged (diff=0); exactly one done pulse.
5. Back-to-back: hold start=1 with x=10,y=4 then x=4,y=10 → done pulses 5 cycles apart; diff=6, bout=0, then diff=64'hFFFF_FFFF_FFFF_FFFA, bout=1.
6. Reset mid-op: start x=100,y=1, then drop rst_n at cycle 2 for one cycle → busy=0, done never pulses, diff=0, bout=0. The next start x=100,y=1 yields diff=99.
